matrix_mem_ctrl: RTL

Memory stage of the matrix coprocessor, directly downstream of the fetch/decode/execute controller. It owns a 256-byte single-port data RAM and services single-element READ/WRITE plus 25-element bursts that load the 5x5 operand matrices A/B for the ALU and store result matrix C back to RAM. The controller drives it with a level start/done handshake.

---
 rtl/matrix_mem_ctrl_pkg.sv | 35 +++
 rtl/matrix_mem_ctrl_if.sv | 28 ++
 rtl/matrix_mem_ctrl_ram.sv | 22 ++
 rtl/matrix_mem_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/matrix_mem_ctrl_pkg.sv
// Shared constants for the matrix coprocessor memory stage: op codes, FSM states, matrix geometry.
// The MEM_CLEAR_EN macro decides whether op 5 (CLEAR) is a legal operation.
package mem_ctrl_pkg;

  localparam int DEPTH    = 256;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int ELEMS    = 25;
  localparam int ELEM_W   = 8;
  localparam int MATRIX_W = ELEMS * ELEM_W;

  localparam logic [2:0] OP_READ    = 3'd0;
  localparam logic [2:0] OP_WRITE   = 3'd1;
  localparam logic [2:0] OP_LOAD_A  = 3'd2;
  localparam logic [2:0] OP_LOAD_B  = 3'd3;
  localparam logic [2:0] OP_STORE_C = 3'd4;
  localparam logic [2:0] OP_CLEAR   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_BURST_RD,
    S_BURST_WR,
    S_CLEAR,
    S_DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef MEM_CLEAR_EN
    return (op <= OP_CLEAR);
`else
    return (op < OP_CLEAR);
`endif
  endfunction

endpackage

// File: rtl/matrix_mem_ctrl_if.sv
// Controller-to-memory-stage bus: level start/done handshake, element data and the three matrix buses.
// master = fetch/decode/execute controller side, slave = matrix_mem_ctrl.
interface matrix_mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                start;
  logic [2:0]          op;
  logic [ADDR_W-1:0]   addr;
  logic [ELEM_W-1:0]   data_in;
  logic [ELEM_W-1:0]   data_out;
  logic [MATRIX_W-1:0] matrix_a;
  logic [MATRIX_W-1:0] matrix_b;
  logic [MATRIX_W-1:0] matrix_c;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, op, addr, data_in, matrix_c,
    input  data_out, matrix_a, matrix_b, busy, done, err
  );

  modport slave (
    input  start, op, addr, data_in, matrix_c,
    output data_out, matrix_a, matrix_b, busy, done, err
  );

endinterface

// File: rtl/matrix_mem_ctrl_ram.sv
// Single-port synchronous data RAM: read-first, one-cycle read latency, write committed on the issuing edge.
// Contents are deliberately not reset.
module mem_ram #(
  parameter  int DEPTH  = 256,
  parameter  int DATA_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/matrix_mem_ctrl.sv
// Memory stage of the matrix coprocessor: single READ/WRITE, 25-element LOAD_A/LOAD_B/STORE_C bursts.
// Define MEM_CLEAR_EN to build the whole-RAM CLEAR op; otherwise op 5 is reported as illegal.
module matrix_mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  matrix_mem_ctrl_if.slave bus
);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   base;
  logic [2:0]          op_r;
  logic [ELEM_W-1:0]   wdata;
  logic [ELEM_W-1:0]   data_out_r;
  logic [MATRIX_W-1:0] mat_a;
  logic [MATRIX_W-1:0] mat_b;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [ELEM_W-1:0]   ram_din;
  logic [ELEM_W-1:0]   ram_dout;

  logic [4:0]          k_wr;
  logic [4:0]          k_rd;
  logic [ADDR_W-1:0]   wr_last;

  // Reads return one edge late, so the element being captured trails the issue counter by one.
  assign k_wr    = cnt[4:0];
  assign k_rd    = cnt[4:0] - 5'd1;
  assign wr_last = (op_r == OP_WRITE) ? '0 : ADDR_W'(ELEMS - 1);

  mem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (ELEM_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = base + cnt;
    ram_din  = wdata;
    case (state)
      S_BURST_WR: begin
        ram_we = 1'b1;
        if (op_r == OP_STORE_C) ram_din = bus.matrix_c[ELEM_W*int'(k_wr) +: ELEM_W];
      end
`ifdef MEM_CLEAR_EN
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = cnt;
        ram_din  = '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      base       <= '0;
      op_r       <= OP_READ;
      wdata      <= '0;
      data_out_r <= '0;
      mat_a      <= '0;
      mat_b      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r  <= bus.op;
            base  <= bus.addr;
            wdata <= bus.data_in;
            cnt   <= '0;
            if (!op_legal(bus.op)) begin
              state  <= S_DONE;
              done_r <= 1'b1;
              err_r  <= 1'b1;
            end else begin
              busy_r <= 1'b1;
              case (bus.op)
                OP_READ:              state <= S_RD_WAIT;
                OP_LOAD_A, OP_LOAD_B: state <= S_BURST_RD;
                OP_WRITE, OP_STORE_C: state <= S_BURST_WR;
                default:              state <= S_CLEAR;
              endcase
            end
          end
        end

        S_RD_WAIT: begin
          if (cnt == '0) begin
            cnt <= cnt + 1'b1;
          end else begin
            data_out_r <= ram_dout;
            state      <= S_DONE;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
          end
        end

        S_BURST_RD: begin
          if (cnt != '0) begin
            if (op_r == OP_LOAD_B) mat_b[ELEM_W*int'(k_rd) +: ELEM_W] <= ram_dout;
            else                   mat_a[ELEM_W*int'(k_rd) +: ELEM_W] <= ram_dout;
          end
          if (cnt == ADDR_W'(ELEMS)) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BURST_WR: begin
          if (cnt == wr_last) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef MEM_CLEAR_EN
        S_CLEAR: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        S_DONE: begin
          if (!bus.start) begin
            state  <= S_IDLE;
            done_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out = data_out_r;
  assign bus.matrix_a = mat_a;
  assign bus.matrix_b = mat_b;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule
